// File: rtl/arbiter_pkg.sv
// Shared types and constants for the physical-memory arbiter.
package arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_e;

    // Values accepted by the RR_EN parameter.
    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;

    // Width of a port index / round-robin pointer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin from a start pointer, or lowest index first.
module rr_picker
    import arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PTR_W     = ptr_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [PTR_W-1:0]     start,
    input  logic                 rr_en,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 valid
);

    // Walk the ports from the start index, wrapping once; first pending port wins.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        base   = rr_en ? 32'(start) : 32'd0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = base + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!valid && pending[PTR_W'(idx)]) begin
                winner[PTR_W'(idx)] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter_rr.sv
// N-port arbiter in front of one physical-memory interface; owns the command for a whole transaction.
module pmem_arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned RR_EN     = ARB_MODE_RR
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_W-1:0]                req_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_W-1:0]                pmem_addr,
    output logic [LINE_W-1:0]                pmem_wdata,
    input  logic [LINE_W-1:0]                pmem_rdata,
    input  logic                             pmem_resp,
    output logic [NUM_PORTS-1:0]             grant
);

    localparam int unsigned PTR_W   = ptr_width(NUM_PORTS);
    localparam logic        RR_MODE = (RR_EN == ARB_MODE_RR);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       idx_q,   idx_d;
    arb_op_e                op_q,    op_d;
    logic [ADDR_W-1:0]      addr_q,  addr_d;
    logic [LINE_W-1:0]      wdata_q, wdata_d;
    logic [PTR_W-1:0]       ptr_q,   ptr_d;

    logic                   busy;
    logic                   load;
    logic [NUM_PORTS-1:0]   pending;
    logic [NUM_PORTS-1:0]   pick_pending;
    logic [PTR_W-1:0]       pick_start;
    logic [PTR_W-1:0]       ptr_inc;
    logic [NUM_PORTS-1:0]   win_oh;
    logic                   win_valid;
    logic [PTR_W-1:0]       win_idx;

    assign busy    = (state_q == BUSY);
    assign pending = req_read | req_write;

    // Index after the current owner, wrapping at NUM_PORTS.
    assign ptr_inc = (idx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : idx_q + PTR_W'(1);

    // While busy the owner still shows its request, so it is excluded from the handoff pick.
    assign pick_pending = busy ? (pending & ~grant_q) : pending;
    assign pick_start   = busy ? ptr_inc : ptr_q;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .pending (pick_pending),
        .start   (pick_start),
        .rr_en   (RR_MODE),
        .winner  (win_oh),
        .valid   (win_valid)
    );

    // One-hot winner to binary index for field muxing.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_oh[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Next-state: grant from IDLE, hand off or release on completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                load = win_valid;
            end
            BUSY: begin
                if (pmem_resp) begin
                    ptr_d = ptr_inc;
                    load  = win_valid;
                    if (!win_valid) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Write wins when a port raises read and write together.
        if (load) begin
            state_d = BUSY;
            grant_d = win_oh;
            idx_d   = win_idx;
            op_d    = (|(req_write & win_oh)) ? OP_WRITE : OP_READ;
            addr_d  = req_addr[win_idx];
            wdata_d = req_wdata[win_idx];
        end
    end

    // State, owner, command latches and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant      = grant_q;
    assign pmem_read  = busy && (op_q == OP_READ);
    assign pmem_write = busy && (op_q == OP_WRITE);
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

    // Completion is routed to the owner only; a response while idle is dropped.
    assign req_resp  = (busy && pmem_resp) ? grant_q    : '0;
    assign req_rdata = (busy && pmem_resp) ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Scoreboard bench: three arbiter instances (2-port RR, 2-port fixed, 4-port RR), each with a memory model/monitor.
module tb_pmem_arbiter_rr;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 64;
    localparam int unsigned ND = 3;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          gap;   // cycles since previous completion, 0 = don't care
        int          at;    // absolute cycle of first command cycle, -1 = don't care
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic                  rst_a     [ND];
    logic [3:0]            rrd_a     [ND];
    logic [3:0]            rwr_a     [ND];
    logic [3:0][31:0]      raddr_a   [ND];
    logic [3:0][63:0]      rwd_a     [ND];
    int                    lat_a     [ND];
    int                    stray_cnt [ND];
    int                    resp_cnt  [ND];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {32'hA5A5_A5A5, a};
    endfunction

    function automatic logic [3:0] oh(input int p);
        logic [3:0] v;
        v = 4'd1 << p;
        return v;
    endfunction

    task automatic push(input int d, input int port, input bit wr, input logic [31:0] addr,
                        input logic [63:0] wdata, input int gap, input int at);
        exp_t e;
        e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.gap = gap; e.at = at;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic bit pop_exp(input int d, output exp_t e);
        e.port = 0; e.wr = 1'b0; e.addr = '0; e.wdata = '0; e.gap = 0; e.at = -1;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_resps(input int d, input int n);
        int target;
        target = resp_cnt[d] + n;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (resp_cnt[d] >= target) return;
        end
        chk($sformatf("d%0d resp_timeout", d), 64'(resp_cnt[d]), 64'(target));
    endtask

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int unsigned NP = (d == 2) ? 4 : 2;
        localparam int unsigned RR = (d == 1) ? 0 : 1;

        logic [NP-1:0] resp;
        logic [NP-1:0] gnt;
        logic          pr, pw, presp;
        logic [AW-1:0] pa;
        logic [LW-1:0] pwd, prd, rrd;

        pmem_arbiter_rr #(
            .NUM_PORTS (NP),
            .ADDR_W    (AW),
            .LINE_W    (LW),
            .RR_EN     (RR)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_a[d]),
            .req_read   (rrd_a[d][NP-1:0]),
            .req_write  (rwr_a[d][NP-1:0]),
            .req_addr   (raddr_a[d][NP-1:0]),
            .req_wdata  (rwd_a[d][NP-1:0]),
            .req_resp   (resp),
            .req_rdata  (rrd),
            .pmem_read  (pr),
            .pmem_write (pw),
            .pmem_addr  (pa),
            .pmem_wdata (pwd),
            .pmem_rdata (prd),
            .pmem_resp  (presp),
            .grant      (gnt)
        );

        // Memory model plus monitor: pops the expected transaction when a command starts, checks every cycle.
        initial begin
            exp_t       cur;
            bit         have, busy_prev, cmd;
            int         cnt, since, stray_done;
            logic [3:0] exp_resp;
            have = 1'b0; busy_prev = 1'b0; cmd = 1'b0;
            cnt = 0; since = 1000; stray_done = 0;
            cur.port = 0; cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.gap = 0; cur.at = -1;
            presp = 1'b0;
            prd   = '0;
            @(posedge clk);
            forever begin
                @(negedge clk);
                presp = 1'b0;
                since++;
                if (rst_a[d]) begin
                    chk($sformatf("d%0d rst grant", d), 64'(gnt), 64'd0);
                    chk($sformatf("d%0d rst pmem_read", d), 64'(pr), 64'd0);
                    chk($sformatf("d%0d rst pmem_write", d), 64'(pw), 64'd0);
                    chk($sformatf("d%0d rst pmem_addr", d), 64'(pa), 64'd0);
                    chk($sformatf("d%0d rst pmem_wdata", d), 64'(pwd), 64'd0);
                    chk($sformatf("d%0d rst req_resp", d), 64'(resp), 64'd0);
                    have = 1'b0; busy_prev = 1'b0; cnt = 0;
                end else begin
                    cmd = pr | pw;
                    if (cmd && !busy_prev) begin
                        have = pop_exp(d, cur);
                        chk($sformatf("d%0d cmd_expected", d), 64'(have), 64'd1);
                        if (have && cur.gap > 0)
                            chk($sformatf("d%0d handoff_gap", d), 64'(since), 64'(cur.gap));
                        if (have && cur.at >= 0)
                            chk($sformatf("d%0d cmd_start_cycle", d), 64'(cyc), 64'(cur.at));
                        cnt = 0;
                    end
                    if (cmd && have) begin
                        chk($sformatf("d%0d grant", d), 64'(gnt), 64'(oh(cur.port)));
                        chk($sformatf("d%0d pmem_write", d), 64'(pw), 64'(cur.wr));
                        chk($sformatf("d%0d pmem_read", d), 64'(pr), 64'(!cur.wr));
                        chk($sformatf("d%0d pmem_addr", d), 64'(pa), 64'(cur.addr));
                        if (cur.wr)
                            chk($sformatf("d%0d pmem_wdata", d), 64'(pwd), cur.wdata);
                    end
                    if (!cmd)
                        chk($sformatf("d%0d idle_grant", d), 64'(gnt), 64'd0);
                    if (cmd) begin
                        cnt++;
                        if (cnt >= lat_a[d]) begin
                            presp = 1'b1;
                            prd   = mem_data(pa);
                        end
                    end else if (stray_cnt[d] > stray_done) begin
                        stray_done++;
                        presp = 1'b1;
                        prd   = 64'hDEAD_BEEF_DEAD_BEEF;
                    end
                    #1;
                    exp_resp = (presp && cmd && have) ? oh(cur.port) : 4'd0;
                    if (presp || (|resp)) begin
                        chk($sformatf("d%0d req_resp", d), 64'(resp), 64'(exp_resp));
                        if (exp_resp != 4'd0)
                            chk($sformatf("d%0d req_rdata", d), 64'(rrd), mem_data(cur.addr));
                    end
                    if (presp && cmd) begin
                        resp_cnt[d]++;
                        since = 0;
                    end
                    busy_prev = cmd && !presp;
                end
            end
        end
    end

    // Directed stimulus; expected transactions are pushed before the requests are raised.
    initial begin
        logic [63:0] dval;
        int base;
        for (int d = 0; d < ND; d++) begin
            rst_a[d] = 1'b1; rrd_a[d] = '0; rwr_a[d] = '0; raddr_a[d] = '0; rwd_a[d] = '0;
            lat_a[d] = 2; stray_cnt[d] = 0; resp_cnt[d] = 0;
        end
        repeat (3) tick();
        for (int d = 0; d < ND; d++) rst_a[d] = 1'b0;
        tick();

        // Port 0 reads 0x1000, memory answers on the fifth command cycle; held request re-granted at c+2.
        lat_a[0] = 5;
        push(0, 0, 1'b0, 32'h1000, 64'd0, 0, cyc + 1);
        push(0, 0, 1'b0, 32'h1000, 64'd0, 2, -1);
        raddr_a[0][0] = 32'h1000;
        rrd_a[0][0]   = 1'b1;
        wait_resps(0, 2);
        rrd_a[0][0] = 1'b0;
        tick();

        // Reset, then both ports pending: 0,1,0,1 back-to-back.
        rst_a[0] = 1'b1; tick(); tick(); rst_a[0] = 1'b0; tick();
        lat_a[0] = 2;
        push(0, 0, 1'b0, 32'h100, 64'd0, 0, cyc + 1);
        push(0, 1, 1'b0, 32'h200, 64'd0, 1, -1);
        push(0, 0, 1'b0, 32'h100, 64'd0, 1, -1);
        push(0, 1, 1'b0, 32'h200, 64'd0, 1, -1);
        raddr_a[0][0] = 32'h100; raddr_a[0][1] = 32'h200;
        rrd_a[0] = 4'b0011;
        wait_resps(0, 4);
        rrd_a[0] = '0;
        tick();

        // Port 1 write; requester changes address/data mid-transaction.
        lat_a[0] = 6;
        dval = 64'h0123_4567_89AB_CDEF;
        push(0, 1, 1'b1, 32'h2000, dval, 0, cyc + 1);
        raddr_a[0][1] = 32'h2000; rwd_a[0][1] = dval;
        rwr_a[0][1]   = 1'b1;
        tick(); tick(); tick();
        raddr_a[0][1] = 32'h3000; rwd_a[0][1] = ~dval;
        wait_resps(0, 1);
        rwr_a[0][1] = 1'b0;
        tick();

        // Read and write together: write issued.
        lat_a[0] = 2;
        push(0, 0, 1'b1, 32'h4000, 64'h1111_2222_3333_4444, 0, cyc + 1);
        raddr_a[0][0] = 32'h4000; rwd_a[0][0] = 64'h1111_2222_3333_4444;
        rrd_a[0][0] = 1'b1; rwr_a[0][0] = 1'b1;
        wait_resps(0, 1);
        rrd_a[0][0] = 1'b0; rwr_a[0][0] = 1'b0;
        tick();

        // Stray memory response while idle.
        stray_cnt[0] = stray_cnt[0] + 1;
        repeat (3) tick();

        // Reset during a long transaction abandons it.
        lat_a[0] = 20;
        push(0, 0, 1'b0, 32'h5000, 64'd0, 0, cyc + 1);
        raddr_a[0][0] = 32'h5000;
        rrd_a[0][0]   = 1'b1;
        repeat (3) tick();
        rst_a[0] = 1'b1; rrd_a[0][0] = 1'b0;
        tick(); tick();
        rst_a[0] = 1'b0;
        repeat (3) tick();

        // Fixed priority: both raised from idle, port 0 wins each round.
        lat_a[1] = 2;
        raddr_a[1][0] = 32'h10; raddr_a[1][1] = 32'h20;
        for (int r = 0; r < 3; r++) begin
            push(1, 0, 1'b0, 32'h10, 64'd0, 0, cyc + 1);
            rrd_a[1] = 4'b0011;
            wait_resps(1, 1);
            rrd_a[1] = '0;
            tick();
        end
        // Fixed priority: port 1 alone is granted.
        push(1, 1, 1'b0, 32'h20, 64'd0, 0, cyc + 1);
        rrd_a[1][1] = 1'b1;
        wait_resps(1, 1);
        rrd_a[1] = '0;
        tick();

        // Four ports all pending: 0,1,2,3,0; then port 2 drops: 1,3,0,1.
        lat_a[2] = 1;
        for (int p = 0; p < 4; p++) raddr_a[2][p] = 32'(32'h100 * (p + 1));
        push(2, 0, 1'b0, 32'h100, 64'd0, 0, cyc + 1);
        push(2, 1, 1'b0, 32'h200, 64'd0, 1, -1);
        push(2, 2, 1'b0, 32'h300, 64'd0, 1, -1);
        push(2, 3, 1'b0, 32'h400, 64'd0, 1, -1);
        push(2, 0, 1'b0, 32'h100, 64'd0, 1, -1);
        rrd_a[2] = 4'b1111;
        wait_resps(2, 5);
        rrd_a[2][2] = 1'b0;
        push(2, 1, 1'b0, 32'h200, 64'd0, 1, -1);
        push(2, 3, 1'b0, 32'h400, 64'd0, 1, -1);
        push(2, 0, 1'b0, 32'h100, 64'd0, 1, -1);
        push(2, 1, 1'b0, 32'h200, 64'd0, 1, -1);
        base = resp_cnt[2];
        wait_resps(2, 4);
        rrd_a[2] = '0;
        chk("d2 resp_total", 64'(resp_cnt[2] - base), 64'd4);
        repeat (4) tick();

        chk("d0 queue_drained", 64'(q0.size()), 64'd0);
        chk("d1 queue_drained", 64'(q1.size()), 64'd0);
        chk("d2 queue_drained", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
